mm_stream_feeder: RTL and testbench

//  Upstream feeder and result collector for the 4x4 signed-8-bit matrix-multiply engine.
//  A host preloads two matrices, up to 4x4 each, and their dimensions, then pulses start.
//  The block resets the engine and streams matrix 1 then matrix 2 row-major with col_end/row_end framing.
//  It then counts the engine's valid pulses, tags each result with its (row,col) index and signals done.

---
 rtl/mm_stream_feeder.sv | 254 +++++++++++++++++++++++++
 tb/tb_mm_stream_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_stream_feeder.sv
// mm_stream_feeder: upstream feeder and result collector for a 4x4 signed
// matrix-multiply engine. The host preloads two element buffers and the matrix
// dimensions, then pulses start. The block pulses the engine reset, streams
// matrix 1 then matrix 2 row-major with col_end/row_end framing, and tags each
// engine result with its (row,col) index before signalling done.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start                         begin a run (sampled only in IDLE)
//   cfg_m1_rows..cfg_m2_cols      matrix dimensions, 1..MAXDIM
//   wr_en/wr_sel/wr_addr/wr_data  host buffer write port (IDLE only)
//   busy, done, err               run status
//   mm_rst, mm_in_data,
//   mm_col_end, mm_row_end        stream towards the engine
//   mm_valid, mm_is_legal,
//   mm_out_data                   results from the engine
//   res_valid, res_legal,
//   res_row, res_col, res_data    tagged results
module mm_stream_feeder #(
  parameter int unsigned DW      = 8,
  parameter int unsigned OW      = 20,
  parameter int unsigned MAXDIM  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    cfg_m1_rows,
  input  logic [2:0]    cfg_m1_cols,
  input  logic [2:0]    cfg_m2_rows,
  input  logic [2:0]    cfg_m2_cols,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mm_rst,
  output logic [DW-1:0] mm_in_data,
  output logic          mm_col_end,
  output logic          mm_row_end,
  input  logic          mm_valid,
  input  logic          mm_is_legal,
  input  logic [OW-1:0] mm_out_data,
  output logic          res_valid,
  output logic          res_legal,
  output logic [1:0]    res_row,
  output logic [1:0]    res_col,
  output logic [OW-1:0] res_data
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MMRST,
    S_SEND1,
    S_SEND2,
    S_RESULTS
  } state_t;

  state_t state;

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];

  logic [2:0]    m1_rows, m1_cols, m2_rows, m2_cols;
  logic          legal;
  logic [4:0]    expected;
  logic [4:0]    cnt;
  logic [1:0]    sr, sc;
  logic [1:0]    rr, rc;
  logic [TW-1:0] idle;

  logic          cfg_bad;
  logic [2:0]    cur_rows, cur_cols;
  logic          send_last_col, send_last;
  logic [1:0]    nsr, nsc;

  function automatic logic dim_bad(input logic [2:0] d);
    return (d == 3'd0) || (d > 3'(MAXDIM));
  endfunction

  // True when idx is the final index of a dimension of size n.
  function automatic logic is_last(input logic [1:0] idx, input logic [2:0] n);
    return {1'b0, idx} == (n - 3'd1);
  endfunction

  assign cfg_bad = dim_bad(cfg_m1_rows) || dim_bad(cfg_m1_cols) ||
                   dim_bad(cfg_m2_rows) || dim_bad(cfg_m2_cols);

  // Position of the element following the one currently on the stream.
  always_comb begin
    cur_rows = m1_rows;
    cur_cols = m1_cols;
    if (state == S_SEND2) begin
      cur_rows = m2_rows;
      cur_cols = m2_cols;
    end
    send_last_col = is_last(sc, cur_cols);
    send_last     = send_last_col && is_last(sr, cur_rows);
    nsr           = sr;
    nsc           = sc + 2'd1;
    if (send_last_col) begin
      nsr = sr + 2'd1;
      nsc = 2'd0;
    end
  end

  // Element buffers are deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && wr_en) begin
      if (wr_sel) mem2[wr_addr] <= wr_data;
      else        mem1[wr_addr] <= wr_data;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mm_rst     <= 1'b0;
      mm_in_data <= '0;
      mm_col_end <= 1'b0;
      mm_row_end <= 1'b0;
      res_valid  <= 1'b0;
      res_legal  <= 1'b0;
      res_row    <= 2'd0;
      res_col    <= 2'd0;
      res_data   <= '0;
      m1_rows    <= 3'd0;
      m1_cols    <= 3'd0;
      m2_rows    <= 3'd0;
      m2_cols    <= 3'd0;
      legal      <= 1'b0;
      expected   <= 5'd0;
      cnt        <= 5'd0;
      sr         <= 2'd0;
      sc         <= 2'd0;
      rr         <= 2'd0;
      rc         <= 2'd0;
      idle       <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      mm_rst    <= 1'b0;
      res_valid <= 1'b0;
      res_legal <= 1'b0;
      res_row   <= 2'd0;
      res_col   <= 2'd0;
      res_data  <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              m1_rows  <= cfg_m1_rows;
              m1_cols  <= cfg_m1_cols;
              m2_rows  <= cfg_m2_rows;
              m2_cols  <= cfg_m2_cols;
              legal    <= (cfg_m1_cols == cfg_m2_rows);
              expected <= (cfg_m1_cols == cfg_m2_rows) ?
                          5'(cfg_m1_rows) * 5'(cfg_m2_cols) : 5'd1;
              cnt      <= 5'd0;
              rr       <= 2'd0;
              rc       <= 2'd0;
              idle     <= '0;
              mm_rst   <= 1'b1;
              busy     <= 1'b1;
              state    <= S_MMRST;
            end
          end
        end

        // Engine is in reset this cycle; put matrix 1 element (0,0) on the bus.
        S_MMRST: begin
          state      <= S_SEND1;
          sr         <= 2'd0;
          sc         <= 2'd0;
          mm_in_data <= mem1[4'd0];
          mm_col_end <= is_last(2'd0, m1_cols);
          mm_row_end <= is_last(2'd0, m1_cols) && is_last(2'd0, m1_rows);
        end

        S_SEND1, S_SEND2: begin
          if (send_last) begin
            sr <= 2'd0;
            sc <= 2'd0;
            if (state == S_SEND1) begin
              // Matrix 2 follows back-to-back.
              state      <= S_SEND2;
              mm_in_data <= mem2[4'd0];
              mm_col_end <= is_last(2'd0, m2_cols);
              mm_row_end <= is_last(2'd0, m2_cols) && is_last(2'd0, m2_rows);
            end else begin
              state      <= S_RESULTS;
              mm_in_data <= '0;
              mm_col_end <= 1'b0;
              mm_row_end <= 1'b0;
            end
          end else begin
            sr         <= nsr;
            sc         <= nsc;
            mm_in_data <= (state == S_SEND1) ? mem1[{nsr, nsc}] : mem2[{nsr, nsc}];
            mm_col_end <= is_last(nsc, cur_cols);
            mm_row_end <= is_last(nsc, cur_cols) && is_last(nsr, cur_rows);
          end
        end

        S_RESULTS: begin
          if (mm_valid) begin
            res_valid <= 1'b1;
            res_legal <= mm_is_legal;
            res_data  <= mm_out_data;
            res_row   <= rr;
            res_col   <= rc;
            err       <= (mm_is_legal != legal);
            idle      <= '0;
            cnt       <= cnt + 5'd1;
            if (is_last(rc, m2_cols)) begin
              rc <= 2'd0;
              rr <= rr + 2'd1;
            end else begin
              rc <= rc + 2'd1;
            end
            if ((cnt + 5'd1) == expected) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (idle == TW'(TIMEOUT - 1)) begin
            // Engine went silent: abort the run.
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            idle <= idle + TW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_stream_feeder.sv
// Directed testbench for mm_stream_feeder. Streamed elements and tagged
// results are predicted from shadow copies of the matrices and queued, then
// compared cycle by cycle against the DUT outputs.
module tb_mm_stream_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  cfg_m1_rows, cfg_m1_cols, cfg_m2_rows, cfg_m2_cols;
  logic        wr_en, wr_sel;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, err, mm_rst;
  logic [7:0]  mm_in_data;
  logic        mm_col_end, mm_row_end;
  logic        mm_valid, mm_is_legal;
  logic [19:0] mm_out_data;
  logic        res_valid, res_legal;
  logic [1:0]  res_row, res_col;
  logic [19:0] res_data;

  mm_stream_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_m1_rows (cfg_m1_rows),
    .cfg_m1_cols (cfg_m1_cols),
    .cfg_m2_rows (cfg_m2_rows),
    .cfg_m2_cols (cfg_m2_cols),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mm_rst      (mm_rst),
    .mm_in_data  (mm_in_data),
    .mm_col_end  (mm_col_end),
    .mm_row_end  (mm_row_end),
    .mm_valid    (mm_valid),
    .mm_is_legal (mm_is_legal),
    .mm_out_data (mm_out_data),
    .res_valid   (res_valid),
    .res_legal   (res_legal),
    .res_row     (res_row),
    .res_col     (res_col),
    .res_data    (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] d;
    logic               ce;
    logic               re;
  } sitem_t;

  typedef struct {
    int                 row;
    int                 col;
    logic signed [31:0] d;
    logic               lg;
    logic               dn;
    logic               er;
  } ritem_t;

  sitem_t sq[$];
  ritem_t rq[$];
  int     vals[$];
  int     a [4][4];
  int     b [4][4];
  int     total = 0;
  int     bad = 0;
  int     m1r, m1c, m2r, m2c;
  logic   tb_legal;
  int     exp_cnt, got_cnt, er, ec;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input int r, input int c, input int v);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = {2'(r), 2'(c)};
    wr_data = 8'(v);
    if (sel) b[r][c] = v;
    else     a[r][c] = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_mat(input logic sel, input int rows, input int cols);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        wr(sel, r, c, vals[r*cols + c]);
  endtask

  task automatic set_dims(input int r1, input int c1, input int r2, input int c2);
    m1r = r1; m1c = c1; m2r = r2; m2c = c2;
    cfg_m1_rows = 3'(r1); cfg_m1_cols = 3'(c1);
    cfg_m2_rows = 3'(r2); cfg_m2_cols = 3'(c2);
  endtask

  function automatic int prod(input int r, input int c);
    int s = 0;
    for (int i = 0; i < m1c; i++) s += a[r][i] * b[i][c];
    return s;
  endfunction

  // Start a run and check the reset pulse plus every streamed element. start,
  // a buffer write and mm_valid are held active during the stream; all must be ignored.
  task automatic run_stream();
    sitem_t e;
    sq.delete();
    for (int r = 0; r < m1r; r++)
      for (int c = 0; c < m1c; c++)
        sq.push_back('{32'(a[r][c]), (c == m1c-1), (c == m1c-1) && (r == m1r-1)});
    for (int r = 0; r < m2r; r++)
      for (int c = 0; c < m2c; c++)
        sq.push_back('{32'(b[r][c]), (c == m2c-1), (c == m2c-1) && (r == m2r-1)});
    tb_legal = (m1c == m2r);
    exp_cnt  = tb_legal ? m1r*m2c : 1;
    got_cnt  = 0;
    er       = 0;
    ec       = 0;
    start = 1'b1;
    @(negedge clk);
    chk("mmrst_pulse", mm_rst, 1);
    chk("busy_in_mmrst", busy, 1);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd99;
    mm_valid = 1'b1; mm_is_legal = 1'b1; mm_out_data = 20'd123;
    @(negedge clk);
    chk("mmrst_one_cycle", mm_rst, 0);
    while (sq.size() > 0) begin
      e = sq.pop_front();
      chk("stream_data", $signed(mm_in_data), e.d);
      chk("stream_col_end", mm_col_end, e.ce);
      chk("stream_row_end", mm_row_end, e.re);
      chk("no_res_in_send", res_valid, 0);
      if (sq.size() == 0) begin
        start = 1'b0; wr_en = 1'b0; mm_valid = 1'b0; mm_is_legal = 1'b0; mm_out_data = '0;
      end
      @(negedge clk);
    end
    chk("idle_in_data", mm_in_data, 0);
    chk("idle_col_end", mm_col_end, 0);
    chk("idle_row_end", mm_row_end, 0);
    chk("busy_in_results", busy, 1);
  endtask

  // One engine cycle; a valid result is predicted and queued, then checked.
  task automatic res_step(input logic v, input logic lg, input int d);
    ritem_t it;
    mm_valid = v; mm_is_legal = lg; mm_out_data = 20'(d);
    if (v) begin
      got_cnt++;
      it = '{er, ec, 32'(d), lg, (got_cnt == exp_cnt), (lg != tb_legal)};
      rq.push_back(it);
      ec++;
      if (ec == m2c) begin ec = 0; er++; end
    end
    @(negedge clk);
    mm_valid = 1'b0; mm_is_legal = 1'b0; mm_out_data = '0;
    if (v) begin
      it = rq.pop_front();
      chk("res_valid", res_valid, 1);
      chk("res_row", res_row, it.row);
      chk("res_col", res_col, it.col);
      chk("res_data", $signed(res_data), it.d);
      chk("res_legal", res_legal, it.lg);
      chk("res_done", done, it.dn);
      chk("res_err", err, it.er);
      chk("res_busy", busy, it.dn ? 0 : 1);
    end else begin
      chk("no_res_valid", res_valid, 0);
      chk("no_done", done, 0);
    end
  endtask

  task automatic res_gap(input int n);
    for (int i = 0; i < n; i++) res_step(1'b0, 1'b0, 0);
  endtask

  task automatic legal_results(input int mis_idx);
    int idx = 0;
    for (int r = 0; r < m1r; r++)
      for (int c = 0; c < m2c; c++) begin
        res_gap(idx % 3);
        res_step(1'b1, (idx != mis_idx), prod(r, c));
        idx++;
      end
    res_step(1'b0, 1'b0, 0);
    chk("idle_after_done_busy", busy, 0);
  endtask

  task automatic bad_cfg(input int r1, input int c1, input int r2, input int c2);
    set_dims(r1, c1, r2, c2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("badcfg_err", err, 1);
    chk("badcfg_no_mmrst", mm_rst, 0);
    chk("badcfg_busy", busy, 0);
    @(negedge clk);
    chk("badcfg_err_pulse", err, 0);
    chk("badcfg_still_idle", busy, 0);
    chk("badcfg_no_mmrst2", mm_rst, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    mm_valid = 1'b0; mm_is_legal = 1'b0; mm_out_data = '0;
    set_dims(1, 1, 1, 1);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mm_rst", mm_rst, 0);
    chk("rst_in_data", mm_in_data, 0);
    chk("rst_col_end", mm_col_end, 0);
    chk("rst_row_end", mm_row_end, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // mm_valid while idle is ignored
    mm_valid = 1'b1; mm_is_legal = 1'b1; mm_out_data = 20'd5;
    @(negedge clk);
    mm_valid = 1'b0;
    chk("idle_valid_ignored", res_valid, 0);

    // 2x2 x 2x2
    vals = '{1, 2, 3, 4};  set_mat(1'b0, 2, 2);
    vals = '{5, 6, 7, 8};  set_mat(1'b1, 2, 2);
    set_dims(2, 2, 2, 2);
    run_stream();
    legal_results(-1);

    // 1x4 x 4x1, dot product 0
    vals = '{1, -2, 3, -4}; set_mat(1'b0, 1, 4);
    vals = '{4, 3, 2, 1};   set_mat(1'b1, 4, 1);
    set_dims(1, 4, 4, 1);
    run_stream();
    legal_results(-1);

    // 1x1 sign handling
    vals = '{-128}; set_mat(1'b0, 1, 1);
    vals = '{-128}; set_mat(1'b1, 1, 1);
    set_dims(1, 1, 1, 1);
    run_stream();
    legal_results(-1);

    // Illegal 2x3 x 2x2: single result flagged illegal by the engine
    vals = '{1, 2, 3, 4, 5, 6}; set_mat(1'b0, 2, 3);
    vals = '{7, 8, 9, 10};      set_mat(1'b1, 2, 2);
    set_dims(2, 3, 2, 2);
    run_stream();
    res_gap(2);
    res_step(1'b1, 1'b0, 0);
    res_step(1'b0, 1'b0, 0);

    // Bad configurations
    bad_cfg(0, 2, 2, 2);
    bad_cfg(5, 2, 2, 2);
    bad_cfg(2, 2, 2, 7);

    // rst during SEND1
    vals = '{1, 2, 3, 4}; set_mat(1'b0, 2, 2);
    vals = '{5, 6, 7, 8}; set_mat(1'b1, 2, 2);
    set_dims(2, 2, 2, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_streaming", mm_in_data, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_data", mm_in_data, 0);
    chk("midrst_col_end", mm_col_end, 0);
    chk("midrst_row_end", mm_row_end, 0);
    chk("midrst_mm_rst", mm_rst, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    chk("midrst_idle", busy, 0);

    // New run on retained buffers, engine misreports legality on result 1
    run_stream();
    legal_results(1);

    // Silent engine: timeout after 64 idle cycles (buffers reused)
    set_dims(1, 1, 1, 1);
    run_stream();
    res_gap(63);
    @(negedge clk);
    chk("timeout_done", done, 1);
    chk("timeout_err", err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_res", res_valid, 0);
    @(negedge clk);
    chk("timeout_done_pulse", done, 0);
    chk("timeout_err_pulse", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
